bids_nway: RTL and testbench

BIDS_NWAY -- requirements
Module: bids_nway

---
 rtl/bids_pkg.sv | 49 ++++
 rtl/bids_max_select.sv | 40 ++++
 rtl/bids_nway.sv | 198 +++++++++++++++++++
 tb/tb_bids_nway.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bids_pkg.sv
// Shared types for the n-way sealed-bid auction block.
//   op_e    : controller opcodes carried on C_op
//   state_e : controller state
//   err_e   : controller error code reported on err
//   berr_e  : per-bidder error code reported on bidder_err
//   idx_width() : width of a bidder index for n bidders
package bids_pkg;

  typedef enum logic [3:0] {
    OP_NOOP       = 4'd0,
    OP_UNLOCK     = 4'd1,
    OP_LOCK       = 4'd2,
    OP_SEL_BIDDER = 4'd3,
    OP_LOAD_BAL   = 4'd4,
    OP_SET_MASK   = 4'd5,
    OP_SET_TIMER  = 4'd6,
    OP_BID_CHARGE = 4'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_LOCKED   = 2'd1,
    ST_ROUND    = 2'd2,
    ST_RESULT   = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    ERR_NONE             = 3'd0,
    ERR_BAD_KEY          = 3'd1,
    ERR_ALREADY_UNLOCKED = 3'd2,
    ERR_START_UNLOCKED   = 3'd3,
    ERR_INVALID_OP       = 3'd4,
    ERR_DUP_MAX          = 3'd5,
    ERR_NO_BIDS          = 3'd6,
    ERR_BAD_INDEX        = 3'd7
  } err_e;

  typedef enum logic [1:0] {
    BERR_NONE     = 2'd0,
    BERR_INACTIVE = 2'd1,
    BERR_FUNDS    = 2'd2,
    BERR_DISABLED = 2'd3
  } berr_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bids_max_select.sv
// Combinational maximum finder over the current bids.
//   amt     : NUM_BIDDERS packed amounts, bidder i at [i*BID_W +: BID_W]
//   max_idx : lowest index holding the maximum
//   max_amt : the maximum amount
//   tie     : more than one bidder holds a nonzero maximum
//   none    : every amount is zero
module bids_max_select
  import bids_pkg::*;
#(
  parameter int NUM_BIDDERS = 3,
  parameter int BID_W       = 16,
  parameter int IDX_W       = idx_width(NUM_BIDDERS)
) (
  input  logic [NUM_BIDDERS*BID_W-1:0] amt,
  output logic [IDX_W-1:0]             max_idx,
  output logic [BID_W-1:0]             max_amt,
  output logic                         tie,
  output logic                         none
);

  logic [3:0] hits;

  always_comb begin
    max_idx = '0;
    max_amt = '0;
    hits    = '0;
    for (int i = 0; i < NUM_BIDDERS; i++) begin
      if (amt[i*BID_W +: BID_W] > max_amt) begin
        max_amt = amt[i*BID_W +: BID_W];
        max_idx = IDX_W'(i);
      end
    end
    for (int i = 0; i < NUM_BIDDERS; i++) begin
      if (amt[i*BID_W +: BID_W] == max_amt) hits = hits + 4'd1;
    end
    none = (max_amt == '0);
    tie  = !none && (hits > 4'd1);
  end

endmodule

// File: rtl/bids_nway.sv
// N-way sealed-bid auction controller.
//   clk, reset_n      : clock, asynchronous active-low reset
//   C_op/C_data       : controller opcode and operand, sampled every cycle
//   C_start           : round-active level; a rising edge in LOCKED opens a round
//   bid/retract       : per-bidder one-cycle requests, bid_amt the per-bidder amount
//   ack/win           : per-bidder one-cycle pulses
//   bidder_err        : per-bidder 2-bit error, balance per-bidder balances
//   ready/roundOver   : status, maxBid the winning amount, err the controller error
//
// state       | meaning
// ST_UNLOCKED | configuration ops accepted, rounds blocked
// ST_LOCKED   | only Unlock accepted; C_start rising opens a round
// ST_ROUND    | bids accepted, countdown running
// ST_RESULT   | single cycle picking the winner, then back to LOCKED
//
// The RESULT decision is registered, so win/roundOver/maxBid and the
// duplicate/no-bid errors appear on the first cycle after RESULT.
module bids_nway
  import bids_pkg::*;
#(
  parameter int               NUM_BIDDERS = 3,
  parameter int               BID_W       = 16,
  parameter int               VAL_W       = 32,
  parameter logic [VAL_W-1:0] KEY_RESET   = 32'h0F0F0F0F
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [3:0]                   C_op,
  input  logic [VAL_W-1:0]             C_data,
  input  logic                         C_start,
  input  logic [NUM_BIDDERS-1:0]       bid,
  input  logic [NUM_BIDDERS-1:0]       retract,
  input  logic [NUM_BIDDERS*BID_W-1:0] bid_amt,
  output logic [NUM_BIDDERS-1:0]       ack,
  output logic [NUM_BIDDERS-1:0]       win,
  output logic [NUM_BIDDERS*2-1:0]     bidder_err,
  output logic [NUM_BIDDERS*VAL_W-1:0] balance,
  output logic                         ready,
  output logic                         roundOver,
  output logic [BID_W-1:0]             maxBid,
  output logic [2:0]                   err
);

  localparam int IDX_W = idx_width(NUM_BIDDERS);

  state_e                 state;
  logic [VAL_W-1:0]       key_q, timer_q, cost_q, count_q;
  logic [IDX_W-1:0]       idx_q;
  logic [NUM_BIDDERS-1:0] mask_q;
  logic                   start_q;
  logic [VAL_W-1:0]       bal_q  [NUM_BIDDERS];
  logic [BID_W-1:0]       curr_q [NUM_BIDDERS];

  logic [NUM_BIDDERS*BID_W-1:0] curr_flat;
  logic [IDX_W-1:0]             sel_idx;
  logic [BID_W-1:0]             sel_max;
  logic                         sel_tie, sel_none;
  logic                         unlock_ok;

  genvar g;
  for (g = 0; g < NUM_BIDDERS; g++) begin : g_pack
    assign curr_flat[g*BID_W +: BID_W] = curr_q[g];
    assign balance[g*VAL_W +: VAL_W]   = bal_q[g];
  end

  bids_max_select #(
    .NUM_BIDDERS (NUM_BIDDERS),
    .BID_W       (BID_W),
    .IDX_W       (IDX_W)
  ) u_max (
    .amt     (curr_flat),
    .max_idx (sel_idx),
    .max_amt (sel_max),
    .tie     (sel_tie),
    .none    (sel_none)
  );

  assign unlock_ok = (C_op == OP_UNLOCK) && (C_data == key_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_UNLOCKED;
      key_q      <= KEY_RESET;
      timer_q    <= VAL_W'(15);
      cost_q     <= VAL_W'(1);
      count_q    <= '0;
      idx_q      <= '0;
      mask_q     <= '1;
      start_q    <= 1'b0;
      for (int i = 0; i < NUM_BIDDERS; i++) begin
        bal_q[i]  <= '0;
        curr_q[i] <= '0;
      end
      ack        <= '0;
      win        <= '0;
      bidder_err <= '0;
      ready      <= 1'b0;
      roundOver  <= 1'b0;
      maxBid     <= '0;
      err        <= ERR_NONE;
    end else begin
      start_q    <= C_start;
      ack        <= '0;
      win        <= '0;
      bidder_err <= '0;
      roundOver  <= 1'b0;
      err        <= ERR_NONE;
      ready      <= 1'b1;

      case (state)
        ST_UNLOCKED: begin
          // A start request while unlocked is a controller fault; the op is dropped.
          if (C_start) begin
            err <= ERR_START_UNLOCKED;
          end else begin
            case (C_op)
              OP_NOOP:      ;
              OP_UNLOCK:    err <= ERR_ALREADY_UNLOCKED;
              OP_LOCK: begin
                key_q <= C_data;
                state <= ST_LOCKED;
              end
              OP_SEL_BIDDER: begin
                if (C_data >= VAL_W'(NUM_BIDDERS)) err <= ERR_BAD_INDEX;
                else                               idx_q <= C_data[IDX_W-1:0];
              end
              OP_LOAD_BAL:   bal_q[idx_q] <= C_data;
              OP_SET_MASK:   mask_q <= C_data[NUM_BIDDERS-1:0];
              OP_SET_TIMER:  timer_q <= C_data;
              OP_BID_CHARGE: cost_q <= C_data;
              default:       err <= ERR_INVALID_OP;
            endcase
          end
        end

        ST_LOCKED: begin
          if (C_op == OP_UNLOCK) begin
            if (unlock_ok) state <= ST_UNLOCKED;
            else           err <= ERR_BAD_KEY;
          end else if (C_op != OP_NOOP) begin
            err <= ERR_INVALID_OP;
          end
          if (C_start && !start_q && !unlock_ok) begin
            state   <= ST_ROUND;
            count_q <= timer_q;
            maxBid  <= '0;
            ready   <= 1'b0;
            for (int i = 0; i < NUM_BIDDERS; i++) curr_q[i] <= '0;
          end
        end

        ST_ROUND: begin
          ready <= 1'b0;
          if (count_q != '0) count_q <= count_q - VAL_W'(1);
          // Leaving when the decremented count reaches zero gives exactly
          // `timer` round cycles, and a single cycle for timer 0.
          if (!C_start || (count_q < VAL_W'(2))) state <= ST_RESULT;
        end

        ST_RESULT: begin
          roundOver <= 1'b1;
          state     <= ST_LOCKED;
          if (sel_none) begin
            err <= ERR_NO_BIDS;
          end else if (sel_tie) begin
            err <= ERR_DUP_MAX;
          end else begin
            win[sel_idx]   <= 1'b1;
            maxBid         <= sel_max;
            bal_q[sel_idx] <= bal_q[sel_idx] - VAL_W'(sel_max);
          end
        end

        default: state <= ST_UNLOCKED;
      endcase

      for (int i = 0; i < NUM_BIDDERS; i++) begin
        if (bid[i] || retract[i]) begin
          if (state != ST_ROUND) begin
            bidder_err[2*i +: 2] <= BERR_INACTIVE;
          end else if (retract[i]) begin
            curr_q[i] <= '0;
          end else if (!mask_q[i]) begin
            bidder_err[2*i +: 2] <= BERR_DISABLED;
          end else if ((VAL_W+1)'(bal_q[i]) >=
                       (VAL_W+1)'(bid_amt[i*BID_W +: BID_W]) + (VAL_W+1)'(cost_q)) begin
            curr_q[i] <= bid_amt[i*BID_W +: BID_W];
            bal_q[i]  <= bal_q[i] - cost_q;
            ack[i]    <= 1'b1;
          end else begin
            bidder_err[2*i +: 2] <= BERR_FUNDS;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_bids_nway.sv
// Directed bench for bids_nway: a 3-bidder instance carries the main
// scenarios, a 5-bidder instance shares the controller inputs for the
// index-range check and reset behaviour.
module tb_bids_nway;

  localparam int NB = 3;
  localparam int BW = 16;
  localparam int VW = 32;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [3:0]     C_op = '0;
  logic [VW-1:0]  C_data = '0;
  logic           C_start = 1'b0;
  logic [NB-1:0]  bid = '0, retract = '0;
  logic [NB*BW-1:0] bid_amt = '0;

  logic [NB-1:0]    ack, win;
  logic [NB*2-1:0]  bidder_err;
  logic [NB*VW-1:0] balance;
  logic             ready, roundOver;
  logic [BW-1:0]    maxBid;
  logic [2:0]       err;

  logic [4:0]     bid5 = '0, ret5 = '0;
  logic [5*BW-1:0] amt5 = '0;
  logic [4:0]     ack5, win5;
  logic [9:0]     berr5;
  logic [5*VW-1:0] bal5;
  logic           ready5, over5;
  logic [BW-1:0]  max5;
  logic [2:0]     err5;

  int n_tests = 0;
  int n_fail  = 0;

  bids_nway #(.NUM_BIDDERS(NB)) dut (
    .clk(clk), .reset_n(reset_n), .C_op(C_op), .C_data(C_data), .C_start(C_start),
    .bid(bid), .retract(retract), .bid_amt(bid_amt), .ack(ack), .win(win),
    .bidder_err(bidder_err), .balance(balance), .ready(ready), .roundOver(roundOver),
    .maxBid(maxBid), .err(err)
  );

  bids_nway #(.NUM_BIDDERS(5)) dut5 (
    .clk(clk), .reset_n(reset_n), .C_op(C_op), .C_data(C_data), .C_start(C_start),
    .bid(bid5), .retract(ret5), .bid_amt(amt5), .ack(ack5), .win(win5),
    .bidder_err(berr5), .balance(bal5), .ready(ready5), .roundOver(over5),
    .maxBid(max5), .err(err5)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [3:0] o, input logic [VW-1:0] d);
    C_op = o;
    C_data = d;
    step();
    C_op = '0;
    C_data = '0;
  endtask

  function automatic logic [VW-1:0] bal(input int i);
    return balance[i*VW +: VW];
  endfunction

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", ready, 0);
    chk("rst_err", err, 0);
    chk("rst_bal0", bal(0), 0);
    chk("rst_maxbid", maxBid, 0);
    reset_n = 1'b1;
    step();
    chk("ready_after_rst", ready, 1);

    // Controller errors while unlocked
    op(4'd1, 0);   chk("unlock_twice", err, 2);
    op(4'd0, 0);   chk("err_clears", err, 0);
    op(4'd9, 0);   chk("bad_op", err, 4);
    C_start = 1'b1;
    op(4'd9, 0);   chk("start_unlocked", err, 3);
    C_start = 1'b0;
    op(4'd3, 5);   chk("sel5_nb3", err, 7);
                   chk("sel5_nb5", err5, 7);
    op(4'd3, 2);   chk("sel2_nb5", err5, 0);

    // Load 100/100/100, lock with key 5
    op(4'd3, 0); op(4'd4, 100);
    op(4'd3, 1); op(4'd4, 100);
    op(4'd3, 2); op(4'd4, 100);
    chk("load_bal0", bal(0), 100);
    chk("load_bal1", bal(1), 100);
    chk("load_bal2", bal(2), 100);
    op(4'd2, 5);   chk("lock_err", err, 0);

    bid = 3'b001; bid_amt = {16'd0, 16'd0, 16'd10};
    step();
    bid = '0;
    chk("bid_inactive", bidder_err, 6'b000001);

    op(4'd5, 7);   chk("locked_badop", err, 4);
    op(4'd1, 6);   chk("bad_key", err, 1);
    op(4'd1, 5);   chk("good_key", err, 0);
    op(4'd1, 5);   chk("now_unlocked", err, 2);
    op(4'd2, 5);

    // Round: 10/20/30 -> bidder 2 wins 30
    C_start = 1'b1;
    step();        chk("round_ready", ready, 0);
    bid = 3'b111; bid_amt = {16'd30, 16'd20, 16'd10};
    step();
    bid = '0;
    chk("ack_all", ack, 3'b111);
    C_start = 1'b0;
    step();        chk("no_over_yet", roundOver, 0);
    step();
    chk("win_z", win, 3'b100);
    chk("over1", roundOver, 1);
    chk("maxbid30", maxBid, 30);
    chk("r1_bal0", bal(0), 99);
    chk("r1_bal1", bal(1), 99);
    chk("r1_bal2", bal(2), 69);
    step();
    chk("win_pulse", win, 0);
    chk("ready_back", ready, 1);
    chk("maxbid_hold", maxBid, 30);

    // Tie round 40/40/10
    C_start = 1'b1;
    step();        chk("maxbid_clear", maxBid, 0);
    bid = 3'b111; bid_amt = {16'd10, 16'd40, 16'd40};
    step();
    bid = '0;
    C_start = 1'b0;
    step(); step();
    chk("tie_err", err, 5);
    chk("tie_nowin", win, 0);
    chk("tie_over", roundOver, 1);
    chk("tie_bal2", bal(2), 68);

    // Retract beats bid; later retract empties the round
    C_start = 1'b1;
    step();
    bid = 3'b011; retract = 3'b001; bid_amt = {16'd0, 16'd5, 16'd50};
    step();
    bid = '0; retract = '0;
    chk("retract_ack", ack, 3'b010);
    chk("retract_bal0", bal(0), 98);
    chk("retract_bal1", bal(1), 97);
    retract = 3'b010;
    step();
    retract = '0;
    C_start = 1'b0;
    step(); step();
    chk("nobids_err", err, 6);
    chk("nobids_win", win, 0);

    // Funds boundary: balance 10, cost 1
    op(4'd1, 5); op(4'd3, 0); op(4'd4, 10); op(4'd2, 5);
    C_start = 1'b1;
    step();
    bid = 3'b001; bid_amt = {16'd0, 16'd0, 16'd10};
    step();
    chk("funds_err", bidder_err, 6'b000010);
    chk("funds_bal", bal(0), 10);
    bid_amt = {16'd0, 16'd0, 16'd9};
    step();
    bid = '0;
    chk("funds_exact_ack", ack, 3'b001);
    chk("funds_exact_bal", bal(0), 9);
    C_start = 1'b0;
    step(); step();
    chk("funds_win", win, 3'b001);
    chk("funds_maxbid", maxBid, 9);
    chk("funds_final", bal(0), 0);

    // Timer 3 with C_start held, mask 101
    op(4'd1, 5); op(4'd6, 3); op(4'd5, 5); op(4'd2, 5);
    C_start = 1'b1;
    step();
    bid = 3'b010; bid_amt = {16'd0, 16'd1, 16'd0};
    step();
    bid = '0;
    chk("masked_err", bidder_err, 6'b001100);
    chk("masked_bal", bal(1), 97);
    step();        chk("t3_r2", roundOver, 0);
    step();        chk("t3_r3", roundOver, 0);
    step();        chk("t3_over", roundOver, 1);
    C_start = 1'b0;
    step();

    // Timer 0: single-cycle round, bid in that cycle counts
    op(4'd1, 5); op(4'd3, 0); op(4'd4, 50); op(4'd6, 0); op(4'd5, 7); op(4'd2, 5);
    C_start = 1'b1;
    step();
    bid = 3'b001; bid_amt = {16'd0, 16'd0, 16'd7};
    step();
    bid = '0;
    chk("t0_ack", ack, 3'b001);
    step();
    chk("t0_win", win, 3'b001);
    chk("t0_bal", bal(0), 42);
    C_start = 1'b0;
    step();

    // Reset in the middle of a round
    C_start = 1'b1;
    step();
    bid = 3'b100; bid_amt = {16'd5, 16'd0, 16'd0};
    step();
    bid = '0;
    chk("pre_rst_ack", ack, 3'b100);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_outs", {ack, win, bidder_err, ready, roundOver, maxBid, err}, 0);
    chk("rst_bal2", bal(2), 0);
    chk("rst_outs5", {ack5, win5, berr5, ready5, over5, max5, err5}, 0);
    C_start = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step();
    chk("post_rst_ready", ready, 1);
    chk("post_rst_over", roundOver, 0);
    step();
    chk("post_rst_win", {win, roundOver}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
